// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cnn_pkg                                                      |
// | Description : Shared definitions for the convolution datapath: default     |
// |               word/address widths, the feature-map writer state encoding,  |
// |               pixel clamp limits and a saturating signed add helper that   |
// |               is also used by the pooling averager.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package cnn_pkg;

  localparam int unsigned CNN_DATA_W = 16;
  localparam int unsigned CNN_ADDR_W = 16;

  // Largest and smallest representable signed pixel values.
  localparam logic signed [CNN_DATA_W-1:0] PIX_MAX = {1'b0, {(CNN_DATA_W-1){1'b1}}};
  localparam logic signed [CNN_DATA_W-1:0] PIX_MIN = {1'b1, {(CNN_DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_RD   = 3'd2,
    ST_WT   = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } fmap_wr_state_t;

  // Add at one extra bit of headroom; when the two top bits disagree the
  // true result left the DATA_W range and the sign bit says which way.
  function automatic logic signed [CNN_DATA_W-1:0] sat_add(
    input logic signed [CNN_DATA_W-1:0] a,
    input logic signed [CNN_DATA_W-1:0] b
  );
    logic signed [CNN_DATA_W:0] s;
    s = {a[CNN_DATA_W-1], a} + {b[CNN_DATA_W-1], b};
    if (s[CNN_DATA_W] != s[CNN_DATA_W-1]) begin
      return s[CNN_DATA_W] ? PIX_MIN : PIX_MAX;
    end
    return s[CNN_DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fmap_writer_if                                               |
// | Description : Configuration, pixel-stream and feature-map RAM signals of   |
// |               the feature-map writer.                                      |
// |   cfg_start/cfg_base/cfg_dim/cfg_first : map configuration (to writer)     |
// |   px_valid/px_data -> , <- px_ready     : pixel stream handshake           |
// |   mem_addr/mem_re/mem_we/mem_wdata ->   : RAM command (from writer)        |
// |   mem_rdata                             : RAM read data, 1 cycle latency   |
// |   busy/done                             : status (from writer)             |
// | Modports    : master = writer side, slave = environment side               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface fmap_writer_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W,
  parameter int unsigned ADDR_W = CNN_ADDR_W,
  parameter int unsigned DIM_W  = 8
);
  logic                     cfg_start;
  logic [ADDR_W-1:0]        cfg_base;
  logic [DIM_W-1:0]         cfg_dim;
  logic                     cfg_first;
  logic                     px_valid;
  logic                     px_ready;
  logic signed [DATA_W-1:0] px_data;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_re;
  logic signed [DATA_W-1:0] mem_rdata;
  logic                     mem_we;
  logic signed [DATA_W-1:0] mem_wdata;
  logic                     busy;
  logic                     done;

  modport master (
    input  cfg_start, cfg_base, cfg_dim, cfg_first,
    input  px_valid, px_data, mem_rdata,
    output px_ready, mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );

  modport slave (
    output cfg_start, cfg_base, cfg_dim, cfg_first,
    output px_valid, px_data, mem_rdata,
    input  px_ready, mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fmap_writer_sat_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_adder                                                    |
// | Description : Combinational signed saturating adder. The result is        |
// |               clamped to the DATA_W two's-complement range.               |
// |   a, b : signed addends (DATA_W)                                           |
// |   sum  : clamped signed sum (DATA_W)                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sat_adder
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] sum
);

  generate
    if (DATA_W == CNN_DATA_W) begin : g_pkg
      // Default width: share the exact helper used elsewhere in the datapath.
      assign sum = sat_add(a, b);
    end else begin : g_generic
      logic signed [DATA_W:0] ext;
      assign ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      assign sum = (ext[DATA_W] != ext[DATA_W-1])
                   ? {ext[DATA_W], {(DATA_W-1){~ext[DATA_W]}}}
                   : ext[DATA_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fmap_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fmap_writer                                                  |
// | Description : Writes one output feature map, pixel by pixel in raster     |
// |               order, to base+idx of the feature-map RAM. The first        |
// |               filter of a group overwrites; later filters read, add with  |
// |               saturation, and write back.                                 |
// |   clk, rst : clock, synchronous active-high reset                          |
// |   bus      : fmap_writer_if.master (config, pixel stream, RAM, status)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fmap_writer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W,
  parameter int unsigned ADDR_W = CNN_ADDR_W,
  parameter int unsigned DIM_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  fmap_writer_if.master bus
);

  localparam int unsigned TOT_W = 2 * DIM_W;

  fmap_wr_state_t           state_q, state_d;
  logic [TOT_W-1:0]         idx_q, idx_d;
  logic [TOT_W-1:0]         total_q, total_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     first_q, first_d;
  logic signed [DATA_W-1:0] pix_q, pix_d;
  logic signed [DATA_W-1:0] wdata_q, wdata_d;

  logic [TOT_W-1:0]         dim_ext;
  logic [ADDR_W-1:0]        cur_addr;
  logic                     last_px;
  logic signed [DATA_W-1:0] acc_sum;

  assign dim_ext  = {{DIM_W{1'b0}}, bus.cfg_dim};
  // Address arithmetic wraps modulo 2^ADDR_W.
  assign cur_addr = base_q + ADDR_W'(idx_q);
  assign last_px  = (idx_q == total_q - TOT_W'(1));

  sat_adder #(.DATA_W(DATA_W)) u_sat_adder (
    .a   (bus.mem_rdata),
    .b   (pix_q),
    .sum (acc_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          state_d = (bus.cfg_dim == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.px_valid) begin
          state_d = first_q ? ST_WR : ST_RD;
        end
      end
      ST_RD:   state_d = ST_WT;
      ST_WT:   state_d = ST_WR;
      ST_WR:   state_d = last_px ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d   = idx_q;
    total_d = total_q;
    base_d  = base_q;
    addr_d  = addr_q;
    first_d = first_q;
    pix_d   = pix_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) begin
          base_d  = bus.cfg_base;
          first_d = bus.cfg_first;
          total_d = dim_ext * dim_ext;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (bus.px_valid) begin
          pix_d  = bus.px_data;
          // Address is fixed at handshake so RD and WR see the same value.
          addr_d = cur_addr;
          if (first_q) begin
            wdata_d = bus.px_data;
          end
        end
      end
      ST_WT: begin
        // mem_rdata is valid here, one cycle after the RD request.
        wdata_d = acc_sum;
      end
      ST_WR: begin
        if (!last_px) begin
          idx_d = idx_q + TOT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      total_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      first_q <= 1'b0;
      pix_q   <= '0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      total_q <= total_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      pix_q   <= pix_d;
      wdata_q <= wdata_d;
    end
  end

  // Output decode (Moore)
  logic px_ready_o, mem_re_o, mem_we_o, busy_o, done_o;

  always_comb begin
    px_ready_o = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_RUN:  begin px_ready_o = 1'b1; busy_o = 1'b1; end
      ST_RD:   begin mem_re_o   = 1'b1; busy_o = 1'b1; end
      ST_WT:   begin                    busy_o = 1'b1; end
      ST_WR:   begin mem_we_o   = 1'b1; busy_o = 1'b1; end
      ST_DONE: begin done_o     = 1'b1; busy_o = 1'b1; end
      default: ;
    endcase
  end

  assign bus.px_ready  = px_ready_o;
  assign bus.mem_re    = mem_re_o;
  assign bus.mem_we    = mem_we_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_fmap_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fmap_writer                                               |
// | Description : Self-checking bench for fmap_writer with a 64K-word RAM      |
// |               model, a write/read log and a reference model of the map.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fmap_writer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;

  fmap_writer_if #(.DATA_W(16), .ADDR_W(16), .DIM_W(8)) bus ();

  fmap_writer #(.DATA_W(16), .ADDR_W(16), .DIM_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model and activity log
  logic signed [15:0] ram [0:65535];
  logic               pre_we;
  logic [15:0]        pre_addr;
  logic signed [15:0] pre_data;
  logic               prev_re;
  int                 viol;

  logic [15:0]        w_addr[$];
  logic signed [15:0] w_data[$];
  int                 w_cyc[$];
  logic [15:0]        r_addr[$];
  int                 r_cyc[$];
  int                 done_cyc[$];

  logic signed [15:0] px_src[$];

  initial begin
    cyc     = 0;
    prev_re = 1'b0;
    viol    = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) ram[pre_addr] <= pre_data;
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      w_addr.push_back(bus.mem_addr);
      w_data.push_back(bus.mem_wdata);
      w_cyc.push_back(cyc);
    end
    if (bus.mem_re) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      r_addr.push_back(bus.mem_addr);
      r_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.mem_re && bus.mem_we) viol <= viol + 1;
    else if (bus.px_ready && (bus.mem_re || bus.mem_we || prev_re)) viol <= viol + 1;
    prev_re <= bus.mem_re;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] sat16(input logic signed [15:0] a, input logic signed [15:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic preload(input logic [15:0] a, input logic signed [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_px_ready"}, bus.px_ready, 0);
    check({tag, "_mem_re"}, bus.mem_re, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // mode: 0 = valid held high, 1 = valid pattern 1-0-0, 2 = random valid
  task automatic run_map(input logic [15:0] base, input int dim, input bit first, input int mode,
                         input int stray_at, input bit done_start, input string tag);
    int                 total, p, wb, rb, db, vb, nw, start_cyc;
    bit                 v, hs, seen_done;
    logic [15:0]        ea[$];
    logic signed [15:0] ed[$];
    logic [15:0]        a;
    total = dim * dim;
    for (int i = 0; i < total; i++) begin
      a = base + 16'(i);
      ea.push_back(a);
      ed.push_back(first ? px_src[i] : sat16(ram[a], px_src[i]));
    end
    wb = w_addr.size(); rb = r_addr.size(); db = done_cyc.size(); vb = viol;
    bus.cfg_base  = base;
    bus.cfg_dim   = 8'(dim);
    bus.cfg_first = first;
    bus.cfg_start = 1'b1;
    tick();
    start_cyc = cyc - 1;
    bus.cfg_start = 1'b0;
    p = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 1000 && !seen_done; k++) begin
      if (bus.done) begin
        seen_done = 1'b1;
      end else begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (k % 3 == 0);
          default: v = ($urandom_range(1) == 1);
        endcase
        v = v && (p < total);
        bus.px_valid = v;
        bus.px_data  = v ? px_src[p] : 16'($urandom);
        if (k == stray_at) begin
          bus.cfg_start = 1'b1;
          bus.cfg_dim   = 8'(dim + 3);
          bus.cfg_first = ~first;
        end
        hs = v && bus.px_ready;
        tick();
        bus.cfg_start = 1'b0;
        if (hs) p++;
      end
    end
    bus.px_valid = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    if (done_start && seen_done) begin
      // Start raised during the DONE cycle must be ignored, then taken in IDLE.
      bus.cfg_dim   = 8'd0;
      bus.cfg_start = 1'b1;
      tick();
      check({tag, "_start_in_done_ignored"}, bus.busy, 0);
      tick();
      bus.cfg_start = 1'b0;
      check({tag, "_start_after_done"}, bus.done, 1);
    end
    tick();
    tick();
    nw = w_addr.size() - wb;
    check({tag, "_wr_count"}, nw, total);
    for (int i = 0; i < total && i < nw; i++) begin
      check({tag, "_wr_addr"}, w_addr[wb+i], ea[i]);
      check({tag, "_wr_data"}, w_data[wb+i], ed[i]);
      if (mode == 0 && i > 0) check({tag, "_wr_spacing"}, w_cyc[wb+i] - w_cyc[wb+i-1], first ? 2 : 4);
    end
    if (first) begin
      check({tag, "_rd_count"}, r_addr.size() - rb, 0);
    end else begin
      check({tag, "_rd_count"}, r_addr.size() - rb, total);
      for (int i = 0; i < total && i < nw && rb + i < r_addr.size(); i++) begin
        check({tag, "_rd_addr"}, r_addr[rb+i], ea[i]);
        check({tag, "_rd_to_wr"}, w_cyc[wb+i] - r_cyc[rb+i], 2);
      end
    end
    check({tag, "_done_count"}, done_cyc.size() - db, done_start ? 2 : 1);
    if (done_cyc.size() > db) begin
      if (total == 0) check({tag, "_done_time"}, done_cyc[db], start_cyc + 1);
      else if (nw > 0) check({tag, "_done_time"}, done_cyc[db], w_cyc[wb+nw-1] + 1);
    end
    check({tag, "_protocol"}, viol - vb, 0);
    check({tag, "_busy_end"}, bus.busy, 0);
  endtask

  typedef struct {
    logic signed [15:0] ram_v;
    logic signed [15:0] px;
    bit                 first;
    logic signed [15:0] exp;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[7];
    int          wb0, p, nre;
    bit          v, hs, hit;
    logic [15:0] rb_base;
    int          rdim;

    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cfg_start = 1'b0; bus.cfg_base = '0; bus.cfg_dim = '0; bus.cfg_first = 1'b0;
    bus.px_valid = 1'b0; bus.px_data = '0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Overwrite, dim=3, base 0x0100, pixels 1..9
    px_src.delete();
    for (int i = 1; i <= 9; i++) px_src.push_back(16'(i));
    run_map(16'h0100, 3, 1'b1, 0, -1, 1'b0, "ovw3");
    check("ovw3_ram_last", ram[16'h0108], 9);

    // Accumulate, dim=2, base 0
    preload(16'h0000, 16'sd10); preload(16'h0001, 16'sd20);
    preload(16'h0002, 16'sd30); preload(16'h0003, 16'sd40);
    px_src = {16'sd1, -16'sd2, 16'sd3, -16'sd4};
    run_map(16'h0000, 2, 1'b0, 0, -1, 1'b0, "acc2");
    check("acc2_ram0", ram[0], 11);
    check("acc2_ram1", ram[1], 18);
    check("acc2_ram2", ram[2], 33);
    check("acc2_ram3", ram[3], 36);

    // Single-pixel table: saturation and overwrite
    tbl[0] = '{16'sd32000,  16'sd1000,  1'b0, 16'sd32767};
    tbl[1] = '{-16'sd32000, -16'sd1000, 1'b0, 16'sh8000};
    tbl[2] = '{16'sd10,     16'sd1,     1'b0, 16'sd11};
    tbl[3] = '{-16'sd5,     16'sd3,     1'b0, -16'sd2};
    tbl[4] = '{16'sd1234,   16'sh8000,  1'b1, 16'sh8000};
    tbl[5] = '{16'sd32767,  -16'sd1,    1'b0, 16'sd32766};
    tbl[6] = '{16'sh8000,   -16'sd1,    1'b0, 16'sh8000};
    for (int t = 0; t < 7; t++) begin
      preload(16'h0200, tbl[t].ram_v);
      px_src.delete();
      px_src.push_back(tbl[t].px);
      run_map(16'h0200, 1, tbl[t].first, 0, -1, 1'b0, "tbl");
      if (w_data.size() > 0) check("tbl_wdata", w_data[w_data.size()-1], tbl[t].exp);
      else check("tbl_wdata_present", 0, 1);
    end

    // Backpressure and bubbles, overwrite dim=2
    px_src = {16'sd5, 16'sd6, 16'sd7, 16'sd8};
    run_map(16'h0300, 2, 1'b1, 1, -1, 1'b0, "bubble");

    // dim=0: done without memory traffic
    run_map(16'h0400, 0, 1'b1, 0, -1, 1'b0, "dim0");

    // Address wrap plus start raised in the DONE cycle
    px_src = {16'sd21, 16'sd22, 16'sd23, 16'sd24};
    wb0 = w_addr.size();
    run_map(16'hFFFE, 2, 1'b1, 0, -1, 1'b1, "wrap");
    if (w_addr.size() >= wb0 + 4) begin
      check("wrap_a0", w_addr[wb0],   16'hFFFE);
      check("wrap_a1", w_addr[wb0+1], 16'hFFFF);
      check("wrap_a2", w_addr[wb0+2], 16'h0000);
      check("wrap_a3", w_addr[wb0+3], 16'h0001);
    end else begin
      check("wrap_write_count", w_addr.size() - wb0, 4);
    end

    // Stray cfg_start while busy, accumulate
    for (int i = 0; i < 4; i++) preload(16'h0500 + 16'(i), 16'(100 * i));
    px_src = {16'sd7, -16'sd7, 16'sd100, -16'sd100};
    run_map(16'h0500, 2, 1'b0, 0, 5, 1'b0, "stray");

    // Reset in the WT state of pixel 2, accumulate
    preload(16'h0600, 16'sd100); preload(16'h0601, 16'sd200);
    preload(16'h0602, 16'sd300); preload(16'h0603, 16'sd400);
    px_src = {16'sd1, 16'sd2, 16'sd3, 16'sd4};
    wb0 = w_addr.size();
    bus.cfg_base = 16'h0600; bus.cfg_dim = 8'd2; bus.cfg_first = 1'b0; bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    p = 0; nre = 0; hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (bus.mem_re) begin
        nre++;
        if (nre == 2) hit = 1'b1;
      end
      if (!hit) begin
        v = (p < 4);
        bus.px_valid = v;
        bus.px_data  = v ? px_src[p] : 16'sd0;
        hs = v && bus.px_ready;
        tick();
        if (hs) p++;
      end
    end
    check("rst_reach_rd_px2", hit, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_mid");
    bus.px_valid = 1'b0;
    repeat (3) tick();
    check("rst_writes_before_abort", w_addr.size() - wb0, 1);
    check("rst_ram600", ram[16'h0600], 101);
    check("rst_ram601_untouched", ram[16'h0601], 200);
    run_map(16'h0600, 2, 1'b0, 0, -1, 1'b0, "rst_rerun");
    check("rst_rerun_ram603", ram[16'h0603], 404);

    // Randomized maps against the reference model
    for (int r = 0; r < 12; r++) begin
      rb_base = 16'($urandom);
      rdim    = $urandom_range(5, 1);
      px_src.delete();
      for (int i = 0; i < rdim * rdim; i++) begin
        px_src.push_back(16'($urandom));
        preload(rb_base + 16'(i), 16'($urandom));
      end
      run_map(rb_base, rdim, 1'($urandom_range(1)), $urandom_range(2), -1, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
